iob_native_mem_responder: RTL and testbench

- Responder (slave) end of the native IOb concatenated request/response bus, the counterpart of a CPU-side initiator.
- Decodes a request bus {valid, address, wdata, wstrb}, serves it from an internal word-addressed register memory after a configurable number of wait states, and returns {rdata, ready}.
- Used as scratch RAM / bus-model responder behind the instruction or data bus split.

---
 rtl/iob_native_mem_responder_pkg.sv | 39 +++
 rtl/iob_native_ram_bytewe.sv | 25 ++
 rtl/iob_native_mem_responder.sv | 117 +++++++++++
 tb/tb_iob_native_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/iob_native_mem_responder_pkg.sv
// Shared definitions for the native IOb request/response bus: field widths,
// field positions and the responder FSM encoding.
package iob_native_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Wide enough for LATENCY up to 15.
    localparam int CNT_W = 4;

    // Field positions common to initiators and responders.
    localparam int WSTRB_LSB = 0;
    localparam int READY_POS = 0;
    localparam int RDATA_LSB = 1;

    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int valid_pos(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int wdata_lsb(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_native_ram_bytewe.sv
// Single-port word RAM with per-byte write enables and a registered read port
// (read-before-write on the same address).
module iob_native_ram_bytewe #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/iob_native_mem_responder.sv
// Native IOb responder: accepts one request, waits LATENCY cycles, then returns
// a single-cycle ready with read data from an internal byte-writable RAM.
module iob_native_mem_responder
    import iob_native_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]   req,
    output logic [resp_w(DATA_W)-1:0]          resp,
    output logic                               busy,
    output logic                               err
);

    localparam int STRB_W = DATA_W / 8;

    logic                  req_valid;
    logic [DEPTH_LOG2-1:0] req_index;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [STRB_W-1:0]     req_wstrb;

    assign req_valid = req[valid_pos(ADDR_W, DATA_W)];
    assign req_addr  = req[addr_lsb(DATA_W) +: ADDR_W];
    assign req_index = req_addr[DEPTH_LOG2+1:2];
    assign req_wdata = req[wdata_lsb(DATA_W) +: DATA_W];
    assign req_wstrb = req[WSTRB_LSB +: STRB_W];

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              in_range;
    logic              is_write;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [STRB_W-1:0]     ram_we;
    logic [DATA_W-1:0]     ram_dout;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state == ST_RESP && !in_range) begin
                err <= 1'b1;
            end
        end
    end

    // Any address bit above the word index makes the access out of range.
    assign in_range = (addr_q >> (DEPTH_LOG2 + 2)) == '0;
    assign is_write = |wstrb_q;
    assign ready    = (state == ST_RESP);
    assign busy     = (state != ST_IDLE);

    // In IDLE the RAM is addressed straight from the bus so that a LATENCY=1
    // read has its data registered by the time RESP is entered.
    assign ram_addr = (state == ST_IDLE) ? req_index : addr_q[DEPTH_LOG2+1:2];
    assign ram_we   = (ready && rst_n && in_range) ? wstrb_q : '0;

    iob_native_ram_bytewe #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (wdata_q),
        .dout(ram_dout)
    );

    assign rdata = (ready && !is_write && in_range) ? ram_dout : '0;
    assign resp  = {rdata, ready};

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Randomized scoreboard bench: three responders (LATENCY 1, 3, 4) driven in
// parallel, each checked against a word-array model of the memory.
module tb_iob_native_mem_responder;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int REQ_W      = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int BIG        = 1 << 30;
  localparam int N_RAND     = 150;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int ln, input logic [63:0] act,
                       input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc %0d: got 0x%0h, want 0x%0h", name, ln, cyc, act, want);
    end
  endtask

  function automatic logic [31:0] pool_addr(input int i);
    return (i < 16) ? 32'(i * 4) : 32'((1004 + i) * 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;

    logic              rst_n;
    logic [REQ_W-1:0]  req;
    logic [DATA_W:0]   resp;
    logic              busy;
    logic              err;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_cyc_q[$];
    logic [DATA_W-1:0] mdl [int];
    int                busy_lo = -1;
    int                busy_hi = -2;
    int                err_from = BIG;
    bit                mon_en = 1'b0;
    bit                exp_rdy;

    iob_native_mem_responder #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .DEPTH_LOG2(DEPTH_LOG2),
      .LATENCY   (LAT)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .resp (resp),
      .busy (busy),
      .err  (err)
    );

    // driver: call just after a negedge; returns just after a negedge with
    // the next request allowed immediately.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int gap, input bit junk);
      int e;
      int idx;
      bit inr;
      logic [31:0] exp_v;
      logic [31:0] cur;
      req = {1'b1, addr, wdata, wstrb};
      @(posedge clk);
      #1;
      e = cyc;
      inr = addr < (32'd4 << DEPTH_LOG2);
      idx = int'(addr / 4);
      exp_v = 32'h0;
      if (wstrb == 4'h0) begin
        if (inr) exp_v = mdl[idx];
      end else if (inr) begin
        cur = mdl.exists(idx) ? mdl[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        mdl[idx] = cur;
      end
      exp_q.push_back(exp_v);
      exp_cyc_q.push_back(e + LAT - 1);
      busy_lo = e;
      busy_hi = e + LAT - 1;
      if (!inr && err_from > e + LAT) err_from = e + LAT;
      @(negedge clk);
      for (int k = 0; k < LAT + gap; k++) begin
        // a valid during the ready cycle must be ignored
        if (k == LAT - 1 && junk) req = {1'b1, 32'($urandom), 32'($urandom), 4'($urandom)};
        else req = '0;
        @(negedge clk);
      end
      req = '0;
    endtask

    // Write accepted, then reset sampled on the very next edge.
    task automatic reset_abort(input logic [31:0] addr, input logic [31:0] wdata);
      int e;
      req = {1'b1, addr, wdata, 4'hF};
      @(posedge clk);
      #1;
      e = cyc;
      if (LAT == 1) begin
        exp_q.push_back(32'h0);
        exp_cyc_q.push_back(e);
      end
      busy_lo = e;
      busy_hi = e;
      @(negedge clk);
      req = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      err_from = BIG;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
      if (mon_en) begin
        exp_rdy = exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc;
        check("ready", g, 64'(resp[0]), 64'(exp_rdy));
        if (exp_rdy) begin
          check("rdata", g, 64'(resp[DATA_W:1]), 64'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end else begin
          check("idle_rdata", g, 64'(resp[DATA_W:1]), 64'h0);
          if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
          end
        end
        check("busy", g, 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
        if (cyc >= err_from) check("err_set", g, 64'(err), 64'h1);
        else if (cyc < err_from - 1) check("err_clr", g, 64'(err), 64'h0);
      end
    end

    initial begin
      logic [31:0] ra;
      logic [3:0]  rs;
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 20; i++)
        issue(pool_addr(i) | 32'($urandom_range(0, 3)), 32'($urandom), 4'hF, 0, 1'b0);

      issue(32'h10, 32'hA5A5_1234, 4'hF, 0, 1'b0);
      issue(32'h10, 32'h0, 4'h0, 0, 1'b0);
      issue(32'h20, 32'hFFFF_FFFF, 4'hF, 1, 1'b0);
      issue(32'h20, 32'h0000_AB00, 4'h2, 0, 1'b0);
      issue(32'h20, 32'h0, 4'h0, 2, 1'b0);

      issue(32'h1000, 32'h0, 4'h0, 1, 1'b0);
      issue(32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
      issue(32'h0, 32'h0, 4'h0, 1, 1'b0);

      reset_abort(32'h40, 32'h1234_5678);
      issue(32'h40, 32'h0, 4'h0, 0, 1'b0);

      for (int n = 0; n < N_RAND; n++) begin
        ra = pool_addr($urandom_range(0, 19)) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) ra = ra | (32'h1 << $urandom_range(12, 31));
        rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        issue(ra, 32'($urandom), rs, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (LAT + 3) @(negedge clk);
      check("drain", g, 64'(exp_q.size()), 64'h0);
      done_cnt++;
    end
  end

  // final report
  initial begin
    for (int c = 0; c < 30000 && done_cnt < 3; c++) @(posedge clk);
    check("timeout", -1, 64'(done_cnt), 64'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
